// File: rtl/PipeTypes.sv
// rtl/PipeTypes.sv - shared pipeline types for the fetch stage
//
// Purpose : IF/ID pipeline register layout, default reset PC and the
//           sequential PC increment used by the fetch stage.
// Contents: DEFAULT_RESET_PC - default fetch address after reset
//           IF_ID_t          - {valid, pc, instr} handed to decode
//           pc_incr()        - next sequential PC, wraps modulo 2^32
package PipeTypes;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } IF_ID_t;

   function automatic logic [31:0] pc_incr(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order fetch queue with allocate/fill/pop pointers
//
// Purpose : Holds fetched PCs from grant until decode takes them. Entries
//           are allocated in grant order, filled in response order and
//           popped in program order, so three pointers suffice:
//           rd (head) <= fill (oldest unfilled) <= wr (next free).
// Ports   : clk, rst         - clock, asynchronous active-high reset
//           clear_i          - discard every entry (redirect)
//           alloc_i/_pc_i    - allocate one entry holding a PC
//           fill_i/_instr_i  - write the oldest unfilled entry
//           pop_i            - retire the head entry
//           count_o          - allocated entries
//           unfilled_o       - allocated entries still awaiting data
//           head_valid_o     - head entry holds its instruction
//           head_pc_o/_instr_o - head entry contents
module fetch_queue #(
   parameter int DEPTH = 2,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear_i,
   input  logic          alloc_i,
   input  logic [31:0]   alloc_pc_i,
   input  logic          fill_i,
   input  logic [31:0]   fill_instr_i,
   input  logic          pop_i,
   output logic [CW-1:0] count_o,
   output logic [CW-1:0] unfilled_o,
   output logic          head_valid_o,
   output logic [31:0]   head_pc_o,
   output logic [31:0]   head_instr_o
);

   logic [CW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] fill_ptr_q, fill_ptr_d;
   logic [CW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   pc_mem_q    [DEPTH];
   logic [31:0]   instr_mem_q [DEPTH];
   logic          alloc_ok, fill_ok, pop_ok;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign count_o      = wr_ptr_q - rd_ptr_q;
   assign unfilled_o   = wr_ptr_q - fill_ptr_q;
   assign head_valid_o = (fill_ptr_q != rd_ptr_q);
   assign head_pc_o    = pc_mem_q[rd_ptr_q[AW-1:0]];
   assign head_instr_o = instr_mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      pop_ok   = pop_i && head_valid_o && !clear_i;
      // A slot freed by this edge's pop may be reused by this edge's alloc.
      alloc_ok = alloc_i && !clear_i && ((count_o < CW'(DEPTH)) || pop_ok);
      // A response with nothing awaiting data is ignored (e.g. after reset).
      fill_ok  = fill_i && !clear_i && (unfilled_o != '0);

      wr_ptr_d   = wr_ptr_q;
      fill_ptr_d = fill_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (clear_i) begin
         wr_ptr_d   = '0;
         fill_ptr_d = '0;
         rd_ptr_d   = '0;
      end else begin
         if (alloc_ok) wr_ptr_d   = wr_ptr_q + CW'(1);
         if (fill_ok)  fill_ptr_d = fill_ptr_q + CW'(1);
         if (pop_ok)   rd_ptr_d   = rd_ptr_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         fill_ptr_q <= '0;
         rd_ptr_q   <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         fill_ptr_q <= fill_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Payload storage needs no reset: pointers alone decide what is live.
   always_ff @(posedge clk) begin
      if (alloc_ok) pc_mem_q[wr_ptr_q[AW-1:0]]      <= alloc_pc_i;
      if (fill_ok)  instr_mem_q[fill_ptr_q[AW-1:0]] <= fill_instr_i;
   end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with in-order memory interface
//
// Purpose : Issues sequential fetches, tracks them in fetch_queue, discards
//           responses belonging to squashed requests and registers the
//           oldest fetched instruction into the IF/ID pipeline register.
// Ports   : clk, rst                    - clock, async active-high reset
//           stall_if                    - decode not accepting; hold if_id_o
//           flush_if                    - invalidate if_id_o
//           redirect_valid_i/_pc_i      - control-flow redirect
//           imem_req_o/_addr_o/_gnt_i   - request handshake (addr = PC)
//           imem_rvalid_i/_rdata_i      - in-order response
//           if_id_o                     - registered {valid, pc, instr}
module if_stage
   import PipeTypes::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          FQ_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_if,
   input  logic        flush_if,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output IF_ID_t      if_id_o
);

   localparam int            CW      = $clog2(FQ_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   IF_ID_t        if_id_q, if_id_d;

   logic [CW-1:0] fq_count, fq_unfilled, occupancy, drop_sum;
   logic          fq_head_valid;
   logic [31:0]   fq_head_pc, fq_head_instr;
   logic          pop, grant, fill;

   fetch_queue #(.DEPTH(FQ_DEPTH)) u_fetch_queue (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (redirect_valid_i),
      .alloc_i      (grant),
      .alloc_pc_i   (pc_q),
      .fill_i       (fill),
      .fill_instr_i (imem_rdata_i),
      .pop_i        (pop),
      .count_o      (fq_count),
      .unfilled_o   (fq_unfilled),
      .head_valid_o (fq_head_valid),
      .head_pc_o    (fq_head_pc),
      .head_instr_o (fq_head_instr)
   );

   always_comb begin
      pop = !redirect_valid_i && !flush_if && !stall_if && fq_head_valid;

      // Occupancy counts the entry leaving on this edge as already free so a
      // two-entry queue sustains one fetch per cycle with zero-wait memory.
      // Squashed requests still in flight (drop_cnt) reserve capacity too.
      occupancy  = fq_count - (pop ? CW'(1) : CW'(0)) + drop_cnt_q;
      imem_req_o = !rst && !redirect_valid_i && (occupancy < DEPTH_C);
      grant      = imem_req_o && imem_gnt_i;
      fill       = imem_rvalid_i && !redirect_valid_i && (drop_cnt_q == '0);

      pc_d = pc_q;
      if (redirect_valid_i) pc_d = redirect_pc_i;
      else if (grant)       pc_d = pc_incr(pc_q);

      // On redirect every request still in flight becomes a drop; a response
      // arriving on the redirect edge is itself discarded and consumes one.
      drop_sum   = drop_cnt_q + fq_unfilled;
      drop_cnt_d = drop_cnt_q;
      if (redirect_valid_i) begin
         drop_cnt_d = (imem_rvalid_i && (drop_sum != '0)) ? drop_sum - CW'(1) : drop_sum;
      end else if (imem_rvalid_i && (drop_cnt_q != '0)) begin
         drop_cnt_d = drop_cnt_q - CW'(1);
      end

      if_id_d = if_id_q;
      if (redirect_valid_i || flush_if) begin
         if_id_d.valid = 1'b0;
      end else if (!stall_if) begin
         if (fq_head_valid) if_id_d = '{valid: 1'b1, pc: fq_head_pc, instr: fq_head_instr};
         else               if_id_d.valid = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         drop_cnt_q <= '0;
         if_id_q    <= '0;
      end else begin
         pc_q       <= pc_d;
         drop_cnt_q <= drop_cnt_d;
         if_id_q    <= if_id_d;
      end
   end

   assign imem_addr_o = pc_q;
   assign if_id_o     = if_id_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;
   import PipeTypes::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_if = 1'b0;
   logic        flush_if = 1'b0;
   logic        redirect_valid_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'h0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   IF_ID_t      if_id_o;

   logic        rsp_en = 1'b0;
   logic [31:0] pend[$];
   int          errors = 0;
   int          checks = 0;

   if_stage #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(2)) dut (
      .clk              (clk),
      .rst              (rst),
      .stall_if         (stall_if),
      .flush_if         (flush_if),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .imem_req_o       (imem_req_o),
      .imem_addr_o      (imem_addr_o),
      .imem_gnt_i       (imem_gnt_i),
      .imem_rvalid_i    (imem_rvalid_i),
      .imem_rdata_i     (imem_rdata_i),
      .if_id_o          (if_id_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hC0DE_1234;
   endfunction

   // Memory: answers each grant in order, the cycle after it, while rsp_en=1.
   always begin
      @(posedge clk);
      #2;
      if (rsp_en && pend.size() > 0) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = instr_of(pend[0]);
      end else begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = 32'h0;
      end
      @(negedge clk);
      if (rst) begin
         pend.delete();
      end else begin
         assert (!(imem_rvalid_i && pend.size() == 0))
            else $error("protocol violation: response with no request outstanding");
         if (imem_rvalid_i) void'(pend.pop_front());
         if (imem_req_o && imem_gnt_i) pend.push_back(imem_addr_o);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns at the start of cycle 0, the first cycle after reset release.
   task automatic do_reset();
      stall_if = 0; flush_if = 0; redirect_valid_i = 0; redirect_pc_i = 0;
      imem_gnt_i = 0; rsp_en = 0;
      rst = 1;
      step();
      step();
      rst = 0;
   endtask

   task automatic test_reset();
      IF_ID_t exp;
      rst = 1; imem_gnt_i = 1; rsp_en = 0;
      step();
      @(negedge clk);
      checks++;
      if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req_o); end
      checks++;
      if (if_id_o !== '0) begin errors++; $display("FAIL reset_if_id: got %h expected 0", if_id_o); end
      step();
      rst = 0;
      @(negedge clk);
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
         errors++; $display("FAIL reset_first_req: got req=%b addr=%h expected req=1 addr=0", imem_req_o, imem_addr_o);
      end
      step();
      step();
      rst = 1;
      @(negedge clk);
      checks++;
      if (imem_req_o !== 1'b0 || if_id_o !== '0) begin
         errors++; $display("FAIL reset_mid: got req=%b if_id=%h expected req=0 if_id=0", imem_req_o, if_id_o);
      end
      step();
      rsp_en = 1; rst = 0;
      @(negedge clk);
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
         errors++; $display("FAIL reset_mid_restart: got req=%b addr=%h expected req=1 addr=0", imem_req_o, imem_addr_o);
      end
      step(); step(); step();
      @(negedge clk);
      exp = '{valid: 1'b1, pc: 32'h0, instr: instr_of(32'h0)};
      checks++;
      if (if_id_o !== exp) begin errors++; $display("FAIL reset_mid_first_out: got %h expected %h", if_id_o, exp); end
      step();
   endtask

   task automatic test_zero_wait();
      IF_ID_t exp;
      do_reset();
      imem_gnt_i = 1; rsp_en = 1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (c < 3) begin
            if (if_id_o.valid !== 1'b0) begin
               errors++; $display("FAIL zero_wait c=%0d: got valid=%b expected 0", c, if_id_o.valid);
            end
         end else begin
            exp = '{valid: 1'b1, pc: 32'(4 * (c - 3)), instr: instr_of(32'(4 * (c - 3)))};
            if (if_id_o !== exp) begin
               errors++; $display("FAIL zero_wait c=%0d: got %h expected %h", c, if_id_o, exp);
            end
         end
         step();
      end
   endtask

   task automatic test_stall();
      IF_ID_t exp;
      int grants;
      do_reset();
      imem_gnt_i = 1; rsp_en = 1; stall_if = 1;
      grants = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (imem_req_o && imem_gnt_i) grants++;
         checks++;
         if (if_id_o !== '0) begin errors++; $display("FAIL stall_hold c=%0d: got %h expected 0", c, if_id_o); end
         step();
      end
      checks++;
      if (grants !== 2) begin errors++; $display("FAIL stall_grants: got %0d expected 2", grants); end
      stall_if = 0;
      @(negedge clk);
      step();
      for (int c = 5; c < 8; c++) begin
         if (c == 7) stall_if = 1;
         @(negedge clk);
         exp = '{valid: 1'b1, pc: 32'(4 * (c - 5)), instr: instr_of(32'(4 * (c - 5)))};
         checks++;
         if (if_id_o !== exp) begin errors++; $display("FAIL stall_release c=%0d: got %h expected %h", c, if_id_o, exp); end
         step();
      end
      exp = '{valid: 1'b1, pc: 32'h8, instr: instr_of(32'h8)};
      @(negedge clk);
      checks++;
      if (if_id_o !== exp || imem_req_o !== 1'b0) begin
         errors++; $display("FAIL stall_full: got if_id=%h req=%b expected if_id=%h req=0", if_id_o, imem_req_o, exp);
      end
      step();
      stall_if = 0;
      @(negedge clk);
      checks++;
      if (if_id_o !== exp) begin errors++; $display("FAIL stall_held: got %h expected %h", if_id_o, exp); end
      step();
      exp = '{valid: 1'b1, pc: 32'hC, instr: instr_of(32'hC)};
      @(negedge clk);
      checks++;
      if (if_id_o !== exp) begin errors++; $display("FAIL stall_resume: got %h expected %h", if_id_o, exp); end
      step();
   endtask

   task automatic test_redirect();
      IF_ID_t exp;
      do_reset();
      imem_gnt_i = 1; rsp_en = 0;
      step();
      step();
      redirect_valid_i = 1; redirect_pc_i = 32'h100;
      @(negedge clk);
      checks++;
      if (imem_req_o !== 1'b0) begin errors++; $display("FAIL redir_req: got %b expected 0", imem_req_o); end
      step();
      redirect_valid_i = 0; rsp_en = 1;
      @(negedge clk);
      checks++;
      if (imem_req_o !== 1'b0) begin errors++; $display("FAIL redir_drop_hold: got req=%b expected 0", imem_req_o); end
      step();
      @(negedge clk);
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || if_id_o.valid !== 1'b0) begin
         errors++; $display("FAIL redir_target: got req=%b addr=%h valid=%b expected req=1 addr=00000100 valid=0",
                            imem_req_o, imem_addr_o, if_id_o.valid);
      end
      step();
      step();
      @(negedge clk);
      checks++;
      if (if_id_o.valid !== 1'b0) begin errors++; $display("FAIL redir_no_stale: got valid=%b pc=%h expected valid=0", if_id_o.valid, if_id_o.pc); end
      step();
      exp = '{valid: 1'b1, pc: 32'h100, instr: instr_of(32'h100)};
      @(negedge clk);
      checks++;
      if (if_id_o !== exp) begin errors++; $display("FAIL redir_out: got %h expected %h", if_id_o, exp); end
      step();
   endtask

   task automatic test_redirect_rvalid();
      IF_ID_t exp;
      do_reset();
      imem_gnt_i = 1; rsp_en = 1;
      step();
      step();
      redirect_valid_i = 1; redirect_pc_i = 32'h200;
      @(negedge clk);
      step();
      redirect_valid_i = 0;
      @(negedge clk);
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
         errors++; $display("FAIL redir_rv_req: got req=%b addr=%h expected req=1 addr=00000200", imem_req_o, imem_addr_o);
      end
      for (int c = 3; c < 6; c++) begin
         if (c > 3) @(negedge clk);
         checks++;
         if (if_id_o.valid !== 1'b0) begin
            errors++; $display("FAIL redir_rv_no_stale c=%0d: got valid=%b pc=%h expected valid=0", c, if_id_o.valid, if_id_o.pc);
         end
         step();
      end
      exp = '{valid: 1'b1, pc: 32'h200, instr: instr_of(32'h200)};
      @(negedge clk);
      checks++;
      if (if_id_o !== exp) begin errors++; $display("FAIL redir_rv_out: got %h expected %h", if_id_o, exp); end
      step();
   endtask

   task automatic test_gnt_stall();
      IF_ID_t exp;
      do_reset();
      imem_gnt_i = 0; rsp_en = 1;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) imem_gnt_i = 1;
         @(negedge clk);
         checks++;
         if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            errors++; $display("FAIL gnt_hold c=%0d: got req=%b addr=%h expected req=1 addr=0", c, imem_req_o, imem_addr_o);
         end
         step();
      end
      @(negedge clk);
      checks++;
      if (imem_addr_o !== 32'h4) begin errors++; $display("FAIL gnt_advance: got addr=%h expected 00000004", imem_addr_o); end
      step();
      step();
      stall_if = 1; flush_if = 1;
      exp = '{valid: 1'b1, pc: 32'h0, instr: instr_of(32'h0)};
      @(negedge clk);
      checks++;
      if (if_id_o !== exp) begin errors++; $display("FAIL flush_pre: got %h expected %h", if_id_o, exp); end
      step();
      stall_if = 0; flush_if = 0;
      @(negedge clk);
      checks++;
      if (if_id_o.valid !== 1'b0 || if_id_o.pc !== 32'h0) begin
         errors++; $display("FAIL flush_clear: got valid=%b pc=%h expected valid=0 pc=0", if_id_o.valid, if_id_o.pc);
      end
      step();
      exp = '{valid: 1'b1, pc: 32'h4, instr: instr_of(32'h4)};
      @(negedge clk);
      checks++;
      if (if_id_o !== exp) begin errors++; $display("FAIL flush_queue_kept: got %h expected %h", if_id_o, exp); end
      step();
   endtask

   task automatic test_wrap();
      IF_ID_t exp;
      do_reset();
      imem_gnt_i = 1; rsp_en = 1;
      redirect_valid_i = 1; redirect_pc_i = 32'hFFFF_FFFC;
      @(negedge clk);
      step();
      redirect_valid_i = 0;
      @(negedge clk);
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_top: got req=%b addr=%h expected req=1 addr=fffffffc", imem_req_o, imem_addr_o);
      end
      step();
      @(negedge clk);
      checks++;
      if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_zero: got addr=%h expected 00000000", imem_addr_o); end
      step();
      step();
      for (int c = 4; c < 6; c++) begin
         @(negedge clk);
         exp = (c == 4) ? '{valid: 1'b1, pc: 32'hFFFF_FFFC, instr: instr_of(32'hFFFF_FFFC)}
                        : '{valid: 1'b1, pc: 32'h0, instr: instr_of(32'h0)};
         checks++;
         if (if_id_o !== exp) begin errors++; $display("FAIL wrap_out c=%0d: got %h expected %h", c, if_id_o, exp); end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_stall();
      test_redirect();
      test_redirect_rvalid();
      test_gnt_stall();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
